// File: rtl/mvm_row_sequencer_if.sv
// Stream and MVM bus bundle for mvm_row_sequencer: beat input, packed MVM buses,
// MVM result return and the row-result output stream.
interface mvm_row_sequencer_if #(
  parameter int N = 8,
  parameter int S = 8
);
  logic           in_valid;
  logic           in_ready;
  logic [N-1:0]   in_w;
  logic [N-1:0]   in_u;
  logic           in_last;
  logic [S*N-1:0] mvm_w;
  logic [S*N-1:0] mvm_u;
  logic [N-1:0]   mvm_v;
  logic           out_valid;
  logic           out_ready;
  logic [N-1:0]   out_v;
  logic           out_sat;

  modport slave (
    input  in_valid, in_w, in_u, in_last, mvm_v, out_ready,
    output in_ready, mvm_w, mvm_u, out_valid, out_v, out_sat
  );

  modport master (
    output in_valid, in_w, in_u, in_last, mvm_v, out_ready,
    input  in_ready, mvm_w, mvm_u, out_valid, out_v, out_sat
  );
endinterface

// File: rtl/mvm_row_sequencer.sv
// Packs S-element chunks of a matrix row for the MVM, waits out its latency and
// saturating-accumulates the chunk results into one row result.
//
// state    | meaning
// ST_FILL  | accepting beats into the chunk buffers
// ST_WAIT  | buffers frozen while the MVM settles
// ST_ACCUM | fold the MVM result into the row accumulator
// ST_OUT   | row result offered on the output stream
module mvm_row_sequencer #(
  parameter int N       = 8,
  parameter int S       = 8,
  parameter int MVM_LAT = 1
) (
  input logic                CLOCK_50,
  input logic                reset_n,
  mvm_row_sequencer_if.slave bus
);
  localparam int IW = (S > 1) ? $clog2(S) : 1;
  localparam int CW = (MVM_LAT > 1) ? $clog2(MVM_LAT) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(S - 1);
  localparam logic [CW-1:0] LAT_TC   = CW'(MVM_LAT - 1);

  typedef enum logic [1:0] {ST_FILL, ST_WAIT, ST_ACCUM, ST_OUT} state_t;

  state_t         r_state;
  logic [IW-1:0]  r_idx;
  logic [S*N-1:0] r_wbuf;
  logic [S*N-1:0] r_ubuf;
  logic [N-1:0]   r_acc;
  logic           r_sat;
  logic           r_last_seen;
  logic [CW-1:0]  r_lat_cnt;
  logic           r_in_ready;
  logic           r_out_valid;

  logic           w_hs;
  logic           w_chunk_end;
  logic [N:0]     w_sum;

  assign w_hs        = bus.in_valid && r_in_ready;
  assign w_chunk_end = (r_idx == IDX_LAST) || bus.in_last;
  assign w_sum       = {1'b0, r_acc} + {1'b0, bus.mvm_v};

  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      r_state     <= ST_FILL;
      r_idx       <= '0;
      r_wbuf      <= '0;
      r_ubuf      <= '0;
      r_acc       <= '0;
      r_sat       <= 1'b0;
      r_last_seen <= 1'b0;
      r_lat_cnt   <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_FILL: begin
          r_in_ready <= 1'b1;
          if (w_hs) begin
            r_wbuf[int'(r_idx)*N +: N] <= bus.in_w;
            r_ubuf[int'(r_idx)*N +: N] <= bus.in_u;
            r_idx       <= r_idx + 1'b1;
            r_last_seen <= bus.in_last;
            if (w_chunk_end) begin
              r_state    <= ST_WAIT;
              r_lat_cnt  <= '0;
              r_in_ready <= 1'b0;
            end
          end
        end
        ST_WAIT: begin
          if (r_lat_cnt == LAT_TC) r_state <= ST_ACCUM;
          else r_lat_cnt <= r_lat_cnt + 1'b1;
        end
        ST_ACCUM: begin
          // a carry out of the N-bit sum clips the row result and marks it
          if (w_sum[N]) begin
            r_acc <= '1;
            r_sat <= 1'b1;
          end else begin
            r_acc <= w_sum[N-1:0];
          end
          if (r_last_seen) begin
            r_state     <= ST_OUT;
            r_out_valid <= 1'b1;
          end else begin
            r_state    <= ST_FILL;
            r_idx      <= '0;
            r_wbuf     <= '0;
            r_ubuf     <= '0;
            r_in_ready <= 1'b1;
          end
        end
        ST_OUT: begin
          if (bus.out_ready) begin
            r_state     <= ST_FILL;
            r_out_valid <= 1'b0;
            r_acc       <= '0;
            r_sat       <= 1'b0;
            r_idx       <= '0;
            r_wbuf      <= '0;
            r_ubuf      <= '0;
            r_last_seen <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: r_state <= ST_FILL;
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.mvm_w     = r_wbuf;
  assign bus.mvm_u     = r_ubuf;
  assign bus.out_valid = r_out_valid;
  assign bus.out_v     = r_acc;
  assign bus.out_sat   = r_sat;
endmodule

// File: tb/tb_mvm_row_sequencer.sv
// Bench for mvm_row_sequencer: directed rows plus random rows checked against a
// chunk-level dot-product reference, with a saturating MVM model on the bus.
module tb_mvm_row_sequencer;
  localparam int N       = 8;
  localparam int S       = 8;
  localparam int MVM_LAT = 1;
  localparam int MAXV    = (1 << N) - 1;

  typedef struct packed {
    logic [N-1:0] w;
    logic [N-1:0] u;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vecs = 0;
  int   errs = 0;
  beat_t row_q[$];

  always #5 clk = ~clk;

  mvm_row_sequencer_if #(.N(N), .S(S)) bus ();

  mvm_row_sequencer #(.N(N), .S(S), .MVM_LAT(MVM_LAT)) dut (
    .CLOCK_50 (clk),
    .reset_n  (rst_n),
    .bus      (bus)
  );

  function automatic logic [N-1:0] mvm_model(input logic [S*N-1:0] w, input logic [S*N-1:0] u);
    int s;
    s = 0;
    for (int k = 0; k < S; k++) s += int'(w[k*N +: N]) * int'(u[k*N +: N]);
    return (s > MAXV) ? N'(MAXV) : N'(s);
  endfunction

  assign bus.mvm_v = mvm_model(bus.mvm_w, bus.mvm_u);

  // Row result: chunk dot products (MVM-saturated), summed with clipping.
  function automatic logic [N:0] ref_row();
    int acc;
    bit sat;
    int nb;
    acc = 0;
    sat = 1'b0;
    nb  = row_q.size();
    for (int c = 0; c < nb; c += S) begin
      int dot;
      dot = 0;
      for (int k = c; k < c + S && k < nb; k++) dot += int'(row_q[k].w) * int'(row_q[k].u);
      if (dot > MAXV) dot = MAXV;
      if (acc + dot > MAXV) begin
        acc = MAXV;
        sat = 1'b1;
      end else begin
        acc += dot;
      end
    end
    return {sat, N'(acc)};
  endfunction

  function automatic logic [S*N-1:0] ref_bus(input int c, input bit is_w);
    logic [S*N-1:0] r;
    r = '0;
    for (int k = 0; k < S; k++)
      if (c + k < row_q.size()) r[k*N +: N] = is_w ? row_q[c+k].w : row_q[c+k].u;
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input int w, input int u);
    beat_t b;
    b.w = N'(w);
    b.u = N'(u);
    row_q.push_back(b);
  endtask

  task automatic run_row(input string tag, input bit gaps);
    logic [N:0] exp;
    int nb, stall, lat;
    exp = ref_row();
    nb  = row_q.size();
    for (int i = 0; i < nb; i++) begin
      if (gaps && (i % S) != 0) begin
        bus.in_valid = 1'b0;
        repeat ($urandom_range(0, 2)) tick();
      end
      bus.in_valid = 1'b1;
      bus.in_w     = row_q[i].w;
      bus.in_u     = row_q[i].u;
      bus.in_last  = (i == nb - 1);
      stall = 0;
      while (!bus.in_ready && stall < 50) begin
        tick();
        stall++;
      end
      check($sformatf("%s stall%0d", tag, i), stall, (i > 0 && (i % S) == 0) ? MVM_LAT + 1 : 0);
      tick();
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      if ((i % S) == S - 1 || i == nb - 1) begin
        check($sformatf("%s mvm_w@%0d", tag, i), bus.mvm_w, ref_bus(i - (i % S), 1'b1));
        check($sformatf("%s mvm_u@%0d", tag, i), bus.mvm_u, ref_bus(i - (i % S), 1'b0));
      end
    end
    lat = 0;
    while (!bus.out_valid && lat < 50) begin
      tick();
      lat++;
    end
    check({tag, " out_lat"}, lat, MVM_LAT + 1);
    check({tag, " out_v"}, bus.out_v, exp[N-1:0]);
    check({tag, " out_sat"}, bus.out_sat, exp[N]);
  endtask

  task automatic finish_row(input string tag, input int hold);
    bus.out_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      tick();
      check({tag, " hold_valid"}, bus.out_valid, 1'b1);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check({tag, " post_valid"}, bus.out_valid, 1'b0);
    check({tag, " post_ready"}, bus.in_ready, 1'b1);
    check({tag, " post_acc"}, bus.out_v, 0);
  endtask

  task automatic row_basic();
    row_q.delete();
    for (int i = 1; i <= 8; i++) add(1, i);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

  initial begin
    logic [S*N-1:0] e;
    bus.in_valid  = 1'b0;
    bus.in_w      = '0;
    bus.in_u      = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    check("rst in_ready", bus.in_ready, 1'b0);
    check("rst out_valid", bus.out_valid, 1'b0);
    check("rst out_v", bus.out_v, 0);
    check("rst out_sat", bus.out_sat, 1'b0);
    check("rst mvm_w", bus.mvm_w, 0);
    check("rst mvm_u", bus.mvm_u, 0);
    rst_n = 1'b1;
    tick();
    check("rel in_ready", bus.in_ready, 1'b1);

    row_basic();
    run_row("full", 1'b0);
    check("full v36", bus.out_v, 36);
    finish_row("full", 0);

    row_basic();
    for (int i = 0; i < 8; i++) add(2, 1);
    run_row("two", 1'b0);
    check("two v52", bus.out_v, 52);
    finish_row("two", 1);

    row_q.delete();
    for (int i = 0; i < 3; i++) add(1, 5);
    run_row("part", 1'b0);
    check("part v15", bus.out_v, 15);
    finish_row("part", 0);

    row_q.delete();
    add(1, 200);
    add(1, 200);
    for (int i = 0; i < 6; i++) add(0, 0);
    add(1, 10);
    run_row("sat", 1'b0);
    check("sat v255", bus.out_v, 255);
    check("sat flag", bus.out_sat, 1'b1);
    finish_row("sat", 0);

    row_basic();
    run_row("after_sat", 1'b0);
    check("after_sat flag", bus.out_sat, 1'b0);

    // backpressure: offered beat must not be taken while the result waits
    bus.in_valid = 1'b1;
    bus.in_w     = 8'hAB;
    bus.in_u     = 8'hCD;
    bus.in_last  = 1'b0;
    for (int h = 0; h < 5; h++) begin
      tick();
      check("bp out_valid", bus.out_valid, 1'b1);
      check("bp out_v", bus.out_v, 36);
      check("bp out_sat", bus.out_sat, 1'b0);
      check("bp in_ready", bus.in_ready, 1'b0);
      check("bp mvm_w", bus.mvm_w, ref_bus(0, 1'b1));
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("bp hs valid", bus.out_valid, 1'b0);
    check("bp hs ready", bus.in_ready, 1'b1);
    check("bp hs unused", bus.mvm_w, 0);
    tick();
    e = '0;
    e[N-1:0] = 8'hAB;
    check("bp slot0 w", bus.mvm_w, e);
    e[N-1:0] = 8'hCD;
    check("bp slot0 u", bus.mvm_u, e);

    for (int i = 1; i < S; i++) begin
      bus.in_w = N'(i);
      bus.in_u = N'(i + 1);
      tick();
    end
    bus.in_valid = 1'b0;
    check("mid wait ready", bus.in_ready, 1'b0);
    rst_n = 1'b0;
    tick();
    check("mid rst in_ready", bus.in_ready, 1'b0);
    check("mid rst out_valid", bus.out_valid, 1'b0);
    check("mid rst out_v", bus.out_v, 0);
    check("mid rst out_sat", bus.out_sat, 1'b0);
    check("mid rst mvm_w", bus.mvm_w, 0);
    check("mid rst mvm_u", bus.mvm_u, 0);
    rst_n = 1'b1;
    tick();
    row_basic();
    run_row("post_rst", 1'b0);
    check("post_rst v36", bus.out_v, 36);
    check("post_rst sat", bus.out_sat, 1'b0);
    finish_row("post_rst", 0);

    for (int r = 0; r < 12; r++) begin
      int len;
      row_q.delete();
      len = $urandom_range(1, 20);
      for (int i = 0; i < len; i++)
        add($urandom_range(0, (r % 3 == 0) ? 255 : 3), $urandom_range(0, (r % 3 == 0) ? 255 : 40));
      run_row($sformatf("rnd%0d", r), 1'b1);
      finish_row($sformatf("rnd%0d", r), $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/mvm_row_sequencer.md
# mvm_row_sequencer

Front-end driver for `mvm_proposed` in the LSTM accelerator datapath. It accepts one weight/activation element pair per beat over a valid/ready stream and packs S beats into the `w`/`u` buses. It issues each S-element chunk to the MVM, waits out the MVM latency, and saturating-accumulates the per-chunk results of one matrix row. It then returns the row result over a valid/ready output stream, so rows of arbitrary length can be fed through the fixed-width MVM.

## Interface
- `N`, 8, element width in bits (unsigned)
- `S`, 8, elements per MVM chunk; even; matches the MVM's `S`
- `MVM_LAT`, 1, clock edges from stable MVM inputs to valid `v`; ≥1
- `CLOCK_50`  in  1  clock; all logic on rising edge
- `reset_n`  in  1  reset, synchronous, active-low
- `in_valid`  in  1  input beat valid
- `in_ready`  out  1  input beat accepted when `in_valid && in_ready` at an edge
- `in_w`  in  N  weight element
- `in_u`  in  N  activation element
- `in_last`  in  1  beat is the final element of the current row
- `mvm_w`  out  S*N  packed weight bus to the MVM; slot k at bits `[(k+1)*N-1 -: N]`
- `mvm_u`  out  S*N  packed activation bus to the MVM; same slot layout
- `mvm_v`  in  N  MVM result
- `out_valid`  out  1  row result valid
- `out_ready`  in  1  consumer accepts the result
- `out_v`  out  N  saturated row result
- `out_sat`  out  1  sticky flag: the chunk accumulation for this row clipped

## Operation
- Registers: `state`, slot index `idx` (log2 S bits), buffers `wbuf` and `ubuf` (each S*N bits), `acc` (N bits), `sat`, `last_seen`, and a latency counter.
- `mvm_w`/`mvm_u` are driven directly from `wbuf`/`ubuf`. `out_v` = `acc`. `out_sat` = `sat`.
- States: FILL → WAIT → ACCUM → (FILL | OUT) → FILL.
- FILL:
  - `in_ready` = 1.
  - On each handshake: write slot `idx` of both buffers and increment `idx`. Register `last_seen` = `in_last`.
  - When the beat is at `idx == S-1` or carries `in_last`, go to WAIT and clear the latency counter.
- WAIT:
  - `in_ready` = 0. Buffers are frozen.
  - Stays in WAIT for `MVM_LAT` cycles, then goes to ACCUM.
- ACCUM (1 cycle):
  - `acc` ← `acc + mvm_v`, computed N+1 bits wide.
  - If the carry is set, `acc` ← 2^N−1 and `sat` ← 1.
  - If `last_seen`, go to OUT. Otherwise go to FILL with `idx` = 0 and both buffers zeroed.
- OUT:
  - `out_valid` = 1; `out_v` and `out_sat` are held stable.
  - On `out_ready`: go to FILL with `acc` = 0, `sat` = 0, `idx` = 0, buffers zeroed, `last_seen` = 0.
- Partial chunk (`in_last` with `idx < S-1`): unwritten slots stay zero. Zero weight bits select 0 in the MVM, so padding contributes nothing.
- `in_last` on slot S-1 is a full chunk and ends the row.
- `in_ready` is 0 in WAIT, ACCUM and OUT; `in_valid` in those states is ignored and no data is consumed.
- Once `acc` is saturated it stays at 2^N−1 for the rest of the row.

## Timing
- Reset (`reset_n` low at an edge): state = FILL, `idx` = 0, buffers = 0, `acc` = 0, `sat` = 0, latency counter = 0.
  - Resulting output values: `mvm_w` = `mvm_u` = 0, `out_valid` = 0, `out_v` = 0, `out_sat` = 0.
  - `in_ready` = 0 while `reset_n` is low. It returns to 1 in the first cycle after reset is released.
- Reset mid-row (any state) discards all buffered beats and the partial `acc`.
- Let E0 be the edge that accepts a chunk's final beat:
  - Buses are stable from E0 until the ACCUM edge.
  - ACCUM is the cycle after edge E0+`MVM_LAT`.
  - `acc` updates at edge E0+`MVM_LAT`+1.
- On a final chunk, `out_valid` rises after edge E0+`MVM_LAT`+1. With `MVM_LAT` = 1, that is 2 cycles after the last beat.
- Chunk cost is (beats + `MVM_LAT` + 1) cycles. A row adds 1 OUT cycle minimum.
- `in_ready` rises the cycle after the ACCUM or OUT handshake edge.

## Test plan
- Single full chunk: 8 beats `in_w`=1, `in_u`=1..8, `in_last` on beat 8 → `out_v`=36, `out_sat`=0; `out_valid` exactly 2 cycles after the last beat.
- Two-chunk row: chunk A as above; chunk B with 8 beats `in_w`=2, `in_u`=1, last on beat 16 → `out_v`=52 (36+16). `in_ready`=0 for 2 cycles between chunks.
- Partial chunk: 3 beats `in_w`=1, `in_u`=5, last on beat 3 → `mvm_w`/`mvm_u` slots 3..7 = 0, `out_v`=15.
- Saturation: chunk 1 has slots 0,1 with `in_w`=1, `in_u`=200, rest zero (MVM returns 255). Chunk 2 has 1 beat `in_w`=1, `in_u`=10, last → `out_v`=255, `out_sat`=1. The next row has `out_sat`=0.
- Backpressure: hold `out_ready`=0 for 5 cycles with `in_valid`=1 → `out_v`/`out_sat` stable, `in_ready`=0, no beat consumed. After the handshake, the first accepted beat lands in slot 0.
- Reset mid-row: pull `reset_n` low for 1 edge during WAIT → all outputs 0 next cycle. The following single-chunk row from the first scenario returns 36 with no residue.
